mmu_xlate_pipe: RTL

- Registered, table-driven address translator for the MIPS core.
- Two independent channels: instruction fetch (if_) and data access (dm_). Each has a valid/ready handshake and one pipeline register.
- A runtime-writable table of NREG regions matches the address top tag. On a hit it subtracts a per-region offset from the tag and flags peripheral accesses.
- Sits between the core's PC/ALU address outputs and the instruction memory, data memory and peripheral bus.

---
 rtl/mmu_xlate_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mmu_xlate_pipe.sv
// Registered region-table address translator with independent fetch and data channels.
// Optional MMU_FAULT_EN adds per-region write protection and the dm_o_fault output.
module mmu_xlate_pipe #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned NREG   = 4,
  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [TAG_W-1:0]  cfg_lo,
  input  logic [TAG_W-1:0]  cfg_hi,
  input  logic [TAG_W-1:0]  cfg_sub,
  input  logic              cfg_peri,
  input  logic              cfg_en,
  input  logic              cfg_wp,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_o_valid,
  input  logic              if_o_ready,
  output logic [ADDR_W-1:0] if_o_addr,
  output logic              if_o_peri,
  input  logic              dm_valid,
  output logic              dm_ready,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic              dm_we,
  output logic              dm_o_valid,
  input  logic              dm_o_ready,
  output logic [ADDR_W-1:0] dm_o_addr,
  output logic              dm_o_peri,
  output logic              dm_o_we
`ifdef MMU_FAULT_EN
  ,
  output logic              dm_o_fault
`endif
);

  localparam int unsigned LOW_W = ADDR_W - TAG_W;

  logic [TAG_W-1:0] tbl_lo  [NREG];
  logic [TAG_W-1:0] tbl_hi  [NREG];
  logic [TAG_W-1:0] tbl_sub [NREG];
  logic [NREG-1:0]  tbl_peri;
  logic [NREG-1:0]  tbl_en;
`ifdef MMU_FAULT_EN
  logic [NREG-1:0]  tbl_wp;
`else
  logic             unused_wp;
  assign unused_wp = cfg_wp;
`endif

  // Region table; entry 0 resets to the legacy peripheral window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) begin
        tbl_lo[k]   <= (k == 0) ? TAG_W'(4) : '0;
        tbl_hi[k]   <= (k == 0) ? {TAG_W{1'b1}} : '0;
        tbl_sub[k]  <= (k == 0) ? TAG_W'(4) : '0;
        tbl_peri[k] <= (k == 0);
        tbl_en[k]   <= (k == 0);
`ifdef MMU_FAULT_EN
        tbl_wp[k]   <= 1'b0;
`endif
      end
    end else if (cfg_we && (32'(cfg_idx) < NREG)) begin
      tbl_lo[cfg_idx]   <= cfg_lo;
      tbl_hi[cfg_idx]   <= cfg_hi;
      tbl_sub[cfg_idx]  <= cfg_sub;
      tbl_peri[cfg_idx] <= cfg_peri;
      tbl_en[cfg_idx]   <= cfg_en;
`ifdef MMU_FAULT_EN
      tbl_wp[cfg_idx]   <= cfg_wp;
`endif
    end
  end

  logic [TAG_W-1:0]  if_tag, dm_tag;
  logic [TAG_W-1:0]  if_sub, dm_sub;
  logic              if_hit, dm_hit;
  logic              if_peri, dm_peri;
  logic              dm_wp;
  logic [ADDR_W-1:0] if_xaddr, dm_xaddr;

  assign if_tag = if_addr[ADDR_W-1 -: TAG_W];
  assign dm_tag = dm_addr[ADDR_W-1 -: TAG_W];

  // Priority match: scanning downward leaves the lowest-index hit selected
  always_comb begin
    if_hit  = 1'b0;
    if_sub  = '0;
    if_peri = 1'b0;
    dm_hit  = 1'b0;
    dm_sub  = '0;
    dm_peri = 1'b0;
    dm_wp   = 1'b0;
    for (int k = int'(NREG) - 1; k >= 0; k--) begin
      if (tbl_en[k] && (if_tag >= tbl_lo[k]) && (if_tag <= tbl_hi[k])) begin
        if_hit  = 1'b1;
        if_sub  = tbl_sub[k];
        if_peri = tbl_peri[k];
      end
      if (tbl_en[k] && (dm_tag >= tbl_lo[k]) && (dm_tag <= tbl_hi[k])) begin
        dm_hit  = 1'b1;
        dm_sub  = tbl_sub[k];
        dm_peri = tbl_peri[k];
`ifdef MMU_FAULT_EN
        dm_wp   = tbl_wp[k];
`endif
      end
    end
  end

  assign if_xaddr = if_hit ? {TAG_W'(if_tag - if_sub), if_addr[LOW_W-1:0]} : if_addr;
  assign dm_xaddr = dm_hit ? {TAG_W'(dm_tag - dm_sub), dm_addr[LOW_W-1:0]} : dm_addr;

  assign if_ready = !if_o_valid || if_o_ready;
  assign dm_ready = !dm_o_valid || dm_o_ready;

  // Fetch result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_o_valid <= 1'b0;
      if_o_addr  <= '0;
      if_o_peri  <= 1'b0;
    end else if (if_ready) begin
      if_o_valid <= if_valid;
      if (if_valid) begin
        if_o_addr <= if_xaddr;
        if_o_peri <= if_hit && if_peri;
      end
    end
  end

  // Data result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_o_valid <= 1'b0;
      dm_o_addr  <= '0;
      dm_o_peri  <= 1'b0;
      dm_o_we    <= 1'b0;
`ifdef MMU_FAULT_EN
      dm_o_fault <= 1'b0;
`endif
    end else if (dm_ready) begin
      dm_o_valid <= dm_valid;
      if (dm_valid) begin
        dm_o_addr <= dm_xaddr;
        dm_o_peri <= dm_hit && dm_peri;
        dm_o_we   <= dm_we;
`ifdef MMU_FAULT_EN
        dm_o_fault <= dm_we && dm_hit && dm_wp;
`endif
      end
    end
  end

`ifndef MMU_FAULT_EN
  logic unused_dm_wp;
  assign unused_dm_wp = dm_wp;
`endif

endmodule
